// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lock: state encodings, digit width and
// the one-hot button helpers used by the qualifier.
package lock_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic [2:0] {
    S_LOCKED   = 3'd0,
    S_INPUT    = 3'd1,
    S_VERIFY   = 3'd2,
    S_ERROR    = 3'd3,
    S_UNLOCKED = 3'd4,
    S_LOCKOUT  = 3'd5
  } state_t;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0) && ((v & (v - 4'd1)) == 4'b0);
  endfunction

  function automatic logic [DIGIT_W-1:0] onehot_to_idx(input logic [3:0] v);
    logic [DIGIT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = DIGIT_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/input_qualifier.sv
// Turns raw keypad levels into single-cycle events, rejecting ambiguous
// cycles (multiple buttons, or a digit racing enter/clear).
module input_qualifier
  import lock_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         btn,
  input  logic               enter,
  input  logic               clear,
  output logic               digit_ev,
  output logic [DIGIT_W-1:0] digit_idx,
  output logic               enter_ev,
  output logic               clear_ev
);

  logic [3:0] btn_q;
  logic       enter_q;
  logic       clear_q;

  logic [3:0] btn_edge;
  logic       enter_edge;
  logic       clear_edge;
  logic       btn_any;
  logic       discard;

  // Previous values reset high so a key held through reset is not a press.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q   <= '1;
      enter_q <= 1'b1;
      clear_q <= 1'b1;
    end else begin
      btn_q   <= btn;
      enter_q <= enter;
      clear_q <= clear;
    end
  end

  // NOTE: every output of this block is given a value up front so no path
  // through it can infer a latch.
  always_comb begin
    btn_edge   = btn & ~btn_q;
    enter_edge = enter & ~enter_q;
    clear_edge = clear & ~clear_q;
    btn_any    = |btn_edge;
    discard    = (btn_any && !is_onehot4(btn_edge))
              || ((btn != 4'b0) && !is_onehot4(btn))
              || (btn_any && (enter_edge || clear_edge))
              || (enter_edge && clear_edge);
    digit_ev   = btn_any && !discard;
    digit_idx  = onehot_to_idx(btn_edge);
    enter_ev   = enter_edge && !discard;
    clear_ev   = clear_edge && !discard;
  end

endmodule

// File: rtl/code_entry_ctrl.sv
// Keypad door lock sequencer: code assembly, verification, failure counting
// and timed lockout after repeated wrong codes.
module code_entry_ctrl
  import lock_pkg::*;
#(
  parameter int                    CODE_LEN       = 4,
  parameter logic [2*CODE_LEN-1:0] PASSWORD       = 8'hE4,
  parameter int                    MAX_FAIL       = 3,
  parameter int                    LOCKOUT_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [3:0]                        btn,
  input  logic                              enter,
  input  logic                              clear,
  output logic [2:0]                        state,
  output logic                              locked,
  output logic                              unlocked,
  output logic                              error,
  output logic                              lockout,
  output logic [$clog2(CODE_LEN+1)-1:0]     digit_count,
  output logic [$clog2(MAX_FAIL+1)-1:0]     fail_count
);

  localparam int CODE_W  = DIGIT_W * CODE_LEN;
  localparam int CNT_W   = $clog2(CODE_LEN + 1);
  localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int TIMER_W = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0]   CODE_LEN_C = CNT_W'(CODE_LEN);
  localparam logic [FAIL_W-1:0]  MAX_FAIL_C = FAIL_W'(MAX_FAIL);
  localparam logic [TIMER_W-1:0] LOCKOUT_C  = TIMER_W'(LOCKOUT_CYCLES);

  logic               digit_ev;
  logic [DIGIT_W-1:0] digit_idx;
  logic               enter_ev;
  logic               clear_ev;

  state_t             st;
  logic [CODE_W-1:0]  code;
  logic [TIMER_W-1:0] timer;
  logic [FAIL_W-1:0]  fail_inc;
  logic               match;

  input_qualifier u_qual (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .enter     (enter),
    .clear     (clear),
    .digit_ev  (digit_ev),
    .digit_idx (digit_idx),
    .enter_ev  (enter_ev),
    .clear_ev  (clear_ev)
  );

  always_comb begin
    fail_inc = (fail_count == MAX_FAIL_C) ? fail_count : fail_count + 1'b1;
    match    = (digit_count == CODE_LEN_C) && (code == PASSWORD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st          <= S_LOCKED;
      code        <= '0;
      digit_count <= '0;
      fail_count  <= '0;
      timer       <= '0;
    end else begin
      case (st)
        S_LOCKED: begin
          if (digit_ev) begin
            code        <= CODE_W'(digit_idx);
            digit_count <= CNT_W'(1);
            st          <= S_INPUT;
          end
        end
        S_INPUT: begin
          if (clear_ev) begin
            code        <= '0;
            digit_count <= '0;
            st          <= S_LOCKED;
          end else if (enter_ev) begin
            st <= S_VERIFY;
          end else if (digit_ev && (digit_count < CODE_LEN_C)) begin
            code        <= {code[CODE_W-DIGIT_W-1:0], digit_idx};
            digit_count <= digit_count + 1'b1;
          end
        end
        S_VERIFY: begin
          code        <= '0;
          digit_count <= '0;
          if (match) begin
            fail_count <= '0;
            st         <= S_UNLOCKED;
          end else begin
            fail_count <= fail_inc;
            if (fail_inc == MAX_FAIL_C) begin
              timer <= LOCKOUT_C;
              st    <= S_LOCKOUT;
            end else begin
              st <= S_ERROR;
            end
          end
        end
        S_ERROR, S_UNLOCKED: begin
          if (clear_ev) st <= S_LOCKED;
        end
        S_LOCKOUT: begin
          if (timer != '0) timer <= timer - 1'b1;
          // Leaving on the cycle the timer reads 1 gives exactly LOCKOUT_CYCLES.
          if (timer <= TIMER_W'(1)) begin
            fail_count <= '0;
            st         <= S_LOCKED;
          end
        end
        default: st <= S_LOCKED;
      endcase
    end
  end

  assign state    = st;
  assign locked   = (st == S_LOCKED);
  assign unlocked = (st == S_UNLOCKED);
  assign error    = (st == S_ERROR);
  assign lockout  = (st == S_LOCKOUT);

endmodule
